// File: rtl/aes128_pkg.sv
// Shared AES-128 types, constant tables and GF(2^8) helpers for the aes_128_top design.
// Byte 0 of a 128-bit state or key is bits [127:120]; the state is stored column-major.
package aes128_pkg;

    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_e;

    localparam logic [3:0] LAST_ROUND = 4'd10;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Indexed directly by the 4-bit round number; entries outside 1..10 are never used.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mixcolumn(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

endpackage

// File: rtl/aes128_round.sv
// One combinational AES-128 encryption round plus on-the-fly expansion of the next round key.
module aes128_round
    import aes128_pkg::*;
(
    input  aes_state_t  state_i,
    input  aes_state_t  rkey_i,
    input  logic [3:0]  round_i,
    input  logic        final_i,
    output aes_state_t  state_o,
    output aes_state_t  rkey_o
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] n0, n1, n2, n3;
    logic [31:0] temp;
    aes_state_t  sr;
    aes_state_t  mc;

    assign w0 = rkey_i[127:96];
    assign w1 = rkey_i[95:64];
    assign w2 = rkey_i[63:32];
    assign w3 = rkey_i[31:0];

    // SubWord(RotWord(w3)) with the round constant folded into the leading byte
    assign temp = {sbox(w3[23:16]) ^ RCON[round_i], sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    assign n0   = w0 ^ temp;
    assign n1   = w1 ^ n0;
    assign n2   = w2 ^ n1;
    assign n3   = w3 ^ n2;
    assign rkey_o = {n0, n1, n2, n3};

    always_comb begin
        sr = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[127 - 8*(r + 4*c) -: 8] = sbox(state_i[127 - 8*(r + 4*((c + r) % 4)) -: 8]);
            end
        end
    end

    always_comb begin
        mc = '0;
        for (int c = 0; c < 4; c++) begin
            mc[127 - 32*c -: 32] = mixcolumn(sr[127 - 32*c -: 32]);
        end
    end

    assign state_o = (final_i ? sr : mc) ^ rkey_o;

endmodule

// File: rtl/aes_128_top.sv
// Board-level iterative AES-128 encryptor: one round per clock, low ciphertext nibble on LEDs.
// Define AES128_TOP_BTN_SYNC_EN to pass btn through a 2-FF synchronizer before edge detection.
module aes_128_top
    import aes128_pkg::*;
#(
    parameter logic [127:0] KEY       = 128'h000102030405060708090a0b0c0d0e0f,
    parameter logic [127:0] PT_BASE   = 128'h00112233445566778899aabbccddeeff,
    parameter int unsigned  DONE_HOLD = 100_000_000
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       btn,
    output logic [3:0] led,
    output logic       ready_o,
    output logic       done_o
);

    localparam int unsigned HOLD_W = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DONE_HOLD - 1);

    fsm_state_e        state_q;
    logic [3:0]        round_q;
    logic [HOLD_W-1:0] hold_q;
    logic              ready_q;
    logic              done_q;
    logic [3:0]        led_q;
    logic              btn_s;
    logic              btn_prev_q;
    logic              start;
    logic              accept;
    aes_state_t        aes_q, aes_d;
    aes_state_t        rkey_q, rkey_d;
    aes_state_t        rnd_state;
    aes_state_t        rnd_key;

`ifdef AES128_TOP_BTN_SYNC_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    assign btn_s = sync2_q;
`else
    assign btn_s = btn;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_prev_q <= 1'b0;
        end else begin
            btn_prev_q <= btn_s;
        end
    end

    // A held button gives a single start; edges arriving during RUN are dropped, not queued
    assign start  = btn_s & ~btn_prev_q;
    assign accept = start && (state_q != ST_RUN);

    aes128_round u_round (
        .state_i (aes_q),
        .rkey_i  (rkey_q),
        .round_i (round_q),
        .final_i (round_q == LAST_ROUND),
        .state_o (rnd_state),
        .rkey_o  (rnd_key)
    );

    always_comb begin
        aes_d  = aes_q;
        rkey_d = rkey_q;
        if (accept) begin
            aes_d  = (PT_BASE ^ {32{sw}}) ^ KEY;
            rkey_d = KEY;
        end else if (state_q == ST_RUN) begin
            aes_d  = rnd_state;
            rkey_d = rnd_key;
        end
    end

    always_ff @(posedge clk) begin
        aes_q  <= aes_d;
        rkey_q <= rkey_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            hold_q  <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            led_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        state_q <= ST_RUN;
                        round_q <= 4'd1;
                        hold_q  <= '0;
                        ready_q <= 1'b0;
                        done_q  <= 1'b0;
                    end else if (state_q == ST_DONE) begin
                        if (hold_q == HOLD_LAST) begin
                            state_q <= ST_IDLE;
                            hold_q  <= '0;
                            done_q  <= 1'b0;
                        end else begin
                            hold_q <= hold_q + HOLD_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (round_q == LAST_ROUND) begin
                        state_q <= ST_DONE;
                        round_q <= '0;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                        led_q   <= rnd_state[3:0];
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign led     = led_q;
    assign ready_o = ready_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_aes_128_top.sv
// Directed bench for aes_128_top: two instances (Appendix C.1 and Appendix B vectors) share stimulus.
`timescale 1ns/1ps
module tb_aes_128_top;

    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam int HOLD = 20;
`ifdef AES128_TOP_BTN_SYNC_EN
    localparam int ACC_LAT = 3;
`else
    localparam int ACC_LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw;
    logic       btn;
    logic [3:0] led_c, led_b;
    logic       rdy_c, rdy_b, done_c, done_b;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb [256];

    typedef struct {
        logic [3:0] sw;
        logic [3:0] exp_c;
        logic [3:0] exp_b;
    } vec_t;
    vec_t vecs [5];

    always #5 clk = ~clk;

    aes_128_top #(.DONE_HOLD(HOLD)) dut_c (
        .clk(clk), .rst(rst), .sw(sw), .btn(btn),
        .led(led_c), .ready_o(rdy_c), .done_o(done_c)
    );

    aes_128_top #(.KEY(KEY_B), .PT_BASE(PT_B), .DONE_HOLD(HOLD)) dut_b (
        .clk(clk), .rst(rst), .sw(sw), .btn(btn),
        .led(led_b), .ready_o(rdy_b), .done_o(done_b)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // Reference encryptor working on byte arrays with a software key schedule
    function automatic logic [127:0] aes_model(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0] s [16];
        logic [7:0] k [16];
        logic [7:0] t [16];
        logic [7:0] a [4];
        logic [7:0] rc;
        logic [127:0] out;
        for (int i = 0; i < 16; i++) begin
            k[i] = key[127 - 8*i -: 8];
            s[i] = pt[127 - 8*i -: 8] ^ k[i];
        end
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            t[0] = sb[k[13]] ^ rc;
            t[1] = sb[k[14]];
            t[2] = sb[k[15]];
            t[3] = sb[k[12]];
            for (int i = 0; i < 4; i++) k[i] = k[i] ^ t[i];
            for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
            rc = xt(rc);
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    s[rr + 4*c] = t[rr + 4*((c + rr) % 4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int rr = 0; rr < 4; rr++) a[rr] = s[4*c + rr];
                    for (int rr = 0; rr < 4; rr++)
                        s[4*c + rr] = gmul(a[rr], 8'h02) ^ gmul(a[(rr+1)%4], 8'h03)
                                      ^ a[(rr+2)%4] ^ a[(rr+3)%4];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
        end
        for (int i = 0; i < 16; i++) out[127 - 8*i -: 8] = s[i];
        return out;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    // Pulse btn for one cycle; report when done_o fell (if it was high) and when it next rose
    task automatic run_enc(input logic [3:0] swv, output int lat, output int low_rdy,
                           output int drop, output logic [3:0] led_drop_c, output logic [3:0] led_drop_b);
        bit seen_low;
        sw = swv;
        btn = 1'b1;
        lat = 0;
        low_rdy = 0;
        drop = 0;
        led_drop_c = 4'h0;
        led_drop_b = 4'h0;
        seen_low = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n == 1) btn = 1'b0;
            if (!rdy_c) low_rdy++;
            if (!done_c && !seen_low) begin
                seen_low = 1'b1;
                drop = n;
                led_drop_c = led_c;
                led_drop_b = led_b;
            end else if (done_c && seen_low) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic hold_count(output int cnt, output int rdy_low);
        cnt = 1;
        rdy_low = 0;
        for (int n = 0; n < 60; n++) begin
            tick();
            if (!done_c) break;
            cnt++;
            if (!rdy_c) rdy_low++;
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, low_rdy, drop, cnt, hrdy, rises, lowr;
        logic [3:0] ldc, ldb;
        logic [127:0] ct;
        logic prev;

        rst = 1'b1;
        sw  = 4'h0;
        btn = 1'b0;
        build_sbox();

        vecs[0] = '{sw: 4'h0, exp_c: 4'ha, exp_b: 4'h2};
        vecs[1].sw = 4'hf;
        vecs[2].sw = 4'h5;
        vecs[3].sw = 4'ha;
        vecs[4].sw = 4'h3;
        for (int i = 1; i < 5; i++) begin
            ct = aes_model(KEY_C, PT_C ^ {32{vecs[i].sw}});
            vecs[i].exp_c = ct[3:0];
            ct = aes_model(KEY_B, PT_B ^ {32{vecs[i].sw}});
            vecs[i].exp_b = ct[3:0];
        end

        repeat (3) tick();
        check("reset_ready_c", rdy_c, 1);
        check("reset_ready_b", rdy_b, 1);
        check("reset_done_c", done_c, 0);
        check("reset_done_b", done_b, 0);
        check("reset_led_c", led_c, 0);
        check("reset_led_b", led_b, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_enc(vecs[i].sw, lat, low_rdy, drop, ldc, ldb);
            check($sformatf("v%0d_latency", i), lat, ACC_LAT + 10);
            check($sformatf("v%0d_ready_low", i), low_rdy, 10);
            check($sformatf("v%0d_led_c", i), led_c, vecs[i].exp_c);
            check($sformatf("v%0d_led_b", i), led_b, vecs[i].exp_b);
            check($sformatf("v%0d_done_b", i), done_b, 1);
            hold_count(cnt, hrdy);
            check($sformatf("v%0d_hold_len", i), cnt, HOLD);
            check($sformatf("v%0d_hold_ready", i), hrdy, 0);
            check($sformatf("v%0d_idle_ready", i), rdy_c, 1);
            check($sformatf("v%0d_idle_done_b", i), done_b, 0);
        end

        // Button held for 50 cycles gives exactly one encryption
        sw = 4'h0;
        btn = 1'b1;
        rises = 0;
        prev = done_c;
        for (int n = 1; n <= 90; n++) begin
            tick();
            if (n == 50) btn = 1'b0;
            if (done_c && !prev) rises++;
            prev = done_c;
        end
        check("held_btn_rises", rises, 1);
        check("held_btn_led_c", led_c, 4'ha);

        // Extra edges during RUN are ignored
        sw = 4'h5;
        btn = 1'b1;
        rises = 0;
        lowr = 0;
        prev = done_c;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (n == 1 || n == ACC_LAT + 2 || n == ACC_LAT + 5) btn = 1'b0;
            if (n == ACC_LAT + 1 || n == ACC_LAT + 4) btn = 1'b1;
            if (!rdy_c) lowr++;
            if (done_c && !prev) rises++;
            prev = done_c;
        end
        check("run_pulses_rises", rises, 1);
        check("run_pulses_ready_low", lowr, 10);
        check("run_pulses_led_c", led_c, vecs[2].exp_c);
        check("run_pulses_led_b", led_b, vecs[2].exp_b);

        // Start during DONE aborts the hold; led holds the old value through RUN
        run_enc(4'h0, lat, low_rdy, drop, ldc, ldb);
        check("pre_done_led_c", led_c, 4'ha);
        repeat (3) tick();
        check("in_done_still_high", done_c, 1);
        run_enc(4'hf, lat, low_rdy, drop, ldc, ldb);
        check("abort_drop_cycle", drop, ACC_LAT);
        check("abort_led_kept_c", ldc, 4'ha);
        check("abort_led_kept_b", ldb, 4'h2);
        check("abort_latency", lat, ACC_LAT + 10);
        check("abort_led_c", led_c, vecs[1].exp_c);
        check("abort_led_b", led_b, vecs[1].exp_b);
        hold_count(cnt, hrdy);
        check("abort_hold_len", cnt, HOLD);

        // Reset while round 5 is in flight
        sw = 4'h0;
        btn = 1'b1;
        for (int n = 1; n <= ACC_LAT + 4; n++) begin
            tick();
            if (n == 1) btn = 1'b0;
        end
        check("pre_reset_busy", rdy_c, 0);
        rst = 1'b1;
        #1;
        check("midrun_reset_ready_c", rdy_c, 1);
        check("midrun_reset_ready_b", rdy_b, 1);
        check("midrun_reset_done_c", done_c, 0);
        check("midrun_reset_led_c", led_c, 0);
        check("midrun_reset_led_b", led_b, 0);
        tick();
        rst = 1'b0;
        rises = 0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (done_c || done_b) rises++;
        end
        check("post_reset_no_done", rises, 0);
        check("post_reset_led_c", led_c, 0);
        check("post_reset_ready_c", rdy_c, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_128_top.md
# aes_128_top

Board-level AES-128 encryption block for a 100 MHz FPGA demo. Four switches perturb a fixed plaintext and a push-button starts one encryption. An iterative core performs one round per clock, and the low ciphertext nibble is shown on four LEDs. It is the top of the HEA design; its only peers are the board pins.

## Interface
- `KEY`, default `128'h000102030405060708090a0b0c0d0e0f`: cipher key.
- `PT_BASE`, default `128'h00112233445566778899aabbccddeeff`: base plaintext.
- `DONE_HOLD`, default `100_000_000`: cycles `done_o` stays high (1 s at 100 MHz); minimum 1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `sw` in 4: plaintext modifier.
- `btn` in 1: start button, asynchronous level input.
- `led` out 4: `ciphertext[3:0]` of the last completed encryption.
- `ready_o` out 1: start is accepted this cycle.
- `done_o` out 1: ciphertext is valid and hold timer is running.

## Operation
- Plaintext is `PT_BASE ^ {32{sw}}`, sampled on the start-accept edge.
- Start event is a rising edge of the conditioned `btn` (see Configuration).
- FSM states:
  - IDLE: `ready_o`=1. Start → RUN.
  - RUN: `ready_o`=0. Round 1..10 counter; after round 10 → DONE.
  - DONE: `ready_o`=1, `done_o`=1. Hold counter counts `DONE_HOLD` cycles, then → IDLE.
- A start in DONE aborts the hold, clears `done_o` and enters RUN.
- Start events while in RUN are ignored and not queued.
- On accept: state ← `pt ^ KEY`, round key ← `KEY`, round ← 1.
- RUN cycle, round r: SubBytes, ShiftRows, MixColumns (omitted when r=10), AddRoundKey with the round key derived on the fly from the previous round key and `Rcon[r]`.
- Byte order follows FIPS-197: byte 0 = bits [127:120], column-major state.
- `led` updates only on entry to DONE and holds until the next DONE. It is not cleared by a new start.
- Reset mid-RUN or mid-DONE: FSM → IDLE, result discarded.

## Timing
- Reset values: `led`=0, `done_o`=0, `ready_o`=1 (IDLE), counters 0, synchronizer 0.
- Start-to-accept latency with synchronizer: 3 edges after `btn` rises (2 sync FFs + edge register); without it: 1 edge.
- Encryption latency: `done_o` and `led` valid 10 edges after the accept edge.
- `done_o` high for exactly `DONE_HOLD` cycles absent a new start; `ready_o` then stays 1 through the drop to IDLE.
- A `btn` pulse of at least 1 clock is guaranteed to register. A held button produces one start only.

## Configuration
- `AES128_TOP_BTN_SYNC_EN`:
  - Defined: `btn` passes through a 2-FF synchronizer before edge detection.
  - Undefined: `btn` is assumed synchronous and feeds the edge register directly.
  - Both modes: one start per rising edge.

## Structure
- Package `aes128_pkg`:
  - S-box constant table, `Rcon` table.
  - `xtime`/`mixcolumn` functions.
  - 128-bit state typedef.
  - FSM state enum.
- Sub-module `aes128_round`, combinational:
  - Inputs: state, round key, round index, final-round flag.
  - Outputs: next state, next round key.
- Top holds the FSM, counters, synchronizer and LED register.

## Test plan
- Reset then `sw`=0, 10 ns `btn` pulse → `done_o` high; ciphertext `69c4e0d86a7b0430d8cdb78070b4c55a`, `led`=4'b1010; latency 13 cycles from `btn` with sync enabled.
- `KEY`=`2b7e151628aed2a6abf7158809cf4f3c`, `PT_BASE`=`3243f6a8885a308d313198a2e0370734`, `sw`=0 → ciphertext `3925841d02dc09fbdc118597196a0b32`, `led`=4'b0010.
- `DONE_HOLD`=20: `done_o` high exactly 20 cycles, then IDLE with `ready_o`=1; `btn` held high for 50 cycles → exactly one encryption.
- `btn` pulses during RUN → ignored; `ready_o`=0 throughout; single `done_o` rise.
- `btn` during DONE with `sw`=4'hF → `done_o` drops the next cycle and rises 10 cycles after accept. `led` = low nibble of the ciphertext of `PT_BASE ^ {32{4'hF}}` (checked against a software model).
- `rst` asserted on round 5 → `ready_o`=1, `done_o`=0 immediately, `led` keeps reset value 0.
